// File: rtl/data_sram_slave.sv
// data_sram_slave: 32-bit word SRAM slave with byte write enables.
// After reset, a clear sequence zeroes every word before requests are
// serviced. The block also keeps a sticky out-of-range flag and saturating
// counts of serviced reads and writes.
module data_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        mem_ready,
  output logic        err_oob,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned BYTES  = DATA_W / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

  logic [DATA_W-1:0]     mem_q [DEPTH];

  // Request decode: the word index sits above the byte-offset bits, and
  // anything above the index makes the access out of range.
  logic [31:0]           req_hi_c;
  logic [ADDR_WIDTH-1:0] req_idx_c;
  logic                  req_oob_c;
  logic                  req_wr_c;
  logic [DATA_W-1:0]     cur_word_c;

  // Single memory write port shared by the clear sequence and host writes.
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_widx_c;
  logic [DATA_W-1:0]     mem_wword_c;

  assign req_hi_c   = data_sram_addr >> (ADDR_WIDTH + 2);
  assign req_idx_c  = ADDR_WIDTH'(data_sram_addr >> 2);
  assign req_oob_c  = (req_hi_c != 32'h0);
  assign req_wr_c   = (data_sram_wen != 4'h0);
  assign cur_word_c = mem_q[req_idx_c];

  // Next-state, memory write port and status/counter updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    mem_we_c    = 1'b0;
    mem_widx_c  = ptr_q;
    mem_wword_c = cur_word_c;

    case (state_q)
      ST_CLEAR: begin
        // Requests are ignored; zero one word per cycle.
        mem_we_c    = 1'b1;
        mem_widx_c  = ptr_q;
        mem_wword_c = '0;
        rdata_d     = '0;
        ptr_d       = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == LAST_IDX) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        if (data_sram_en) begin
          if (req_oob_c) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            // Read-first: the returned word is the value before any write.
            rdata_d = cur_word_c;
            if (req_wr_c) begin
              mem_we_c   = 1'b1;
              mem_widx_c = req_idx_c;
              for (int b = 0; b < int'(BYTES); b++) begin
                if (data_sram_wen[b]) begin
                  mem_wword_c[8*b +: 8] = data_sram_wdata[8*b +: 8];
                end
              end
            end
          end

          if (req_wr_c) begin
            if (wr_cnt_q != CNT_MAX) begin
              wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
          end else begin
            if (rd_cnt_q != CNT_MAX) begin
              rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // State, pointer, read data, error flag and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage array; contents are not reset, the clear sequence zeroes them.
  always_ff @(posedge clk) begin
    if (!reset && mem_we_c) begin
      mem_q[mem_widx_c] <= mem_wword_c;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign mem_ready       = (state_q == ST_READY);
  assign err_oob         = err_q;
  assign rd_count        = rd_cnt_q;
  assign wr_count        = wr_cnt_q;

endmodule

// File: doc/data_sram_slave.md
DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word-index bits, so DEPTH = 2**ADDR_WIDTH words of 32 bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port data_sram_en, input, 1: access request this cycle.
REQ-005 SHALL have port data_sram_wen, input, 4: byte write enables; nonzero means write, zero means read.
REQ-006 SHALL have port data_sram_addr, input, 32: byte address; word index = addr[ADDR_WIDTH+1:2].
REQ-007 SHALL have port data_sram_wdata, input, 32: write data; byte i = wdata[8i+7:8i].
REQ-008 SHALL have port data_sram_rdata, output, 32: registered read data.
REQ-009 SHALL have port mem_ready, output, 1: high when the clear sequence is done and requests are serviced.
REQ-010 SHALL have port err_oob, output, 1: sticky out-of-range access flag.
REQ-011 SHALL have port rd_count, output, 32: count of serviced reads.
REQ-012 SHALL have port wr_count, output, 32: count of serviced writes.

Function
REQ-013 SHALL implement a two-state FSM, CLEAR and READY; reset forces CLEAR with clear pointer = 0.
REQ-014 In CLEAR, SHALL write 32'h0 to word[ptr] each cycle and increment ptr; after clearing word DEPTH-1, SHALL enter READY on the next edge.
REQ-015 mem_ready SHALL equal (state == READY); with reset sampled at edge E0, mem_ready SHALL rise after edge E(DEPTH).
REQ-016 In CLEAR, SHALL ignore all requests: no memory update, no counter or err_oob change, rdata held at 0.
REQ-017 An access SHALL be serviced only when state == READY and data_sram_en == 1.
REQ-018 An address is out-of-range when addr[31:ADDR_WIDTH+2] != 0; addr[1:0] SHALL be ignored, and misalignment is not an error.
REQ-019 A serviced in-range read SHALL set rdata <= word[index] at the same edge (1-cycle latency).
REQ-020 A serviced in-range write SHALL update only the bytes with wen[i] == 1; rdata SHALL take the pre-write word value (read-first).
REQ-021 A serviced out-of-range access SHALL leave memory unchanged, set rdata <= 0 and set err_oob <= 1.
REQ-022 err_oob SHALL remain 1 until reset.
REQ-023 When en == 0, or in CLEAR, rdata SHALL hold its value (0 in CLEAR).
REQ-024 rd_count SHALL increment on each serviced read and wr_count on each serviced write, including out-of-range accesses.
REQ-025 Both counters SHALL saturate at 32'hFFFF_FFFF with no wrap-around.
REQ-026 Back-to-back accesses SHALL be supported every cycle; a read of a word written in the previous cycle SHALL return the new value.

Reset
REQ-027 While reset is high: rdata = 0, err_oob = 0, rd_count = 0, wr_count = 0, mem_ready = 0, state = CLEAR, ptr = 0.
REQ-028 Reset asserted during CLEAR or READY SHALL restart the clear from word 0; memory contents SHALL be all zero when mem_ready next rises.

Verification (ADDR_WIDTH=4, DEPTH=16)
REQ-029 Release reset, hold en=1 with a write -> mem_ready rises after edge E16; no memory change; wr_count stays 0.
REQ-030 Once READY: write addr 0x8 wen=4'hF wdata=0xDEADBEEF, then read 0x8 next cycle -> rdata=0xDEADBEEF; wr_count=1, rd_count=1.
REQ-031 Write addr 0x8 wen=4'b0101 wdata=0x11223344 over 0xDEADBEEF -> rdata in that cycle = 0xDEADBEEF (read-first); a later read returns 0xDE22BE44.
REQ-032 Read addr 0x40 (out-of-range) -> rdata=0, err_oob=1 and stays 1; a following write to 0x44 leaves all 16 words unchanged.
REQ-033 Assert reset at clear pointer = 7, release -> 16 further clear cycles before mem_ready; read addr 0x8 -> 0; counters=0; err_oob=0.
REQ-034 Force rd_count to 32'hFFFF_FFFE, issue 3 reads -> rd_count=32'hFFFF_FFFF, no wrap.
